rate_detect: RTL and testbench



---
 rtl/rate_detect.sv | 207 ++++++++++++++++++++
 tb/tb_rate_detect.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rate_detect.sv
// rate_detect: measures the half-period of a slow toggling input in clk
// cycles, decodes it back to the 2-bit rate select that produced it, and
// reports lock or loss of signal.
module rate_detect #(
  parameter int unsigned CW    = 28,
  parameter int unsigned HALF0 = 12500001,
  parameter int unsigned HALF1 = 25000001,
  parameter int unsigned HALF2 = 50000001,
  parameter int unsigned HALF3 = 100000001,
  parameter int unsigned TOL   = 1024
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          divClkIn,
  output logic [1:0]    rateSel,
  output logic          rateValid,
  output logic [CW-1:0] halfPeriod,
  output logic          measDone,
  output logic          noSignal
);

  // Saturation value of the interval counter; reaching it with no edge means
  // the input has stopped toggling.
  localparam logic [CW-1:0] MAXCNT = CW'(HALF3 + TOL + 1);

  // Tolerance windows, one bit wider than the counter so HALFk+TOL never wraps
  // and a HALFk below TOL clamps its lower bound at zero.
  localparam logic [CW:0] LO0 = (CW+1)'((HALF0 > TOL) ? (HALF0 - TOL) : 0);
  localparam logic [CW:0] LO1 = (CW+1)'((HALF1 > TOL) ? (HALF1 - TOL) : 0);
  localparam logic [CW:0] LO2 = (CW+1)'((HALF2 > TOL) ? (HALF2 - TOL) : 0);
  localparam logic [CW:0] LO3 = (CW+1)'((HALF3 > TOL) ? (HALF3 - TOL) : 0);
  localparam logic [CW:0] HI0 = (CW+1)'(HALF0 + TOL);
  localparam logic [CW:0] HI1 = (CW+1)'(HALF1 + TOL);
  localparam logic [CW:0] HI2 = (CW+1)'(HALF2 + TOL);
  localparam logic [CW:0] HI3 = (CW+1)'(HALF3 + TOL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Returns {hit, class}; hit=0 means the measurement matches no rate.
  function automatic logic [2:0] classify(input logic [CW-1:0] m);
    logic [CW:0] mx;
    logic [2:0]  r;
    mx = {1'b0, m};
    if (mx >= LO0 && mx <= HI0) begin
      r = {1'b1, 2'd0};
    end else if (mx >= LO1 && mx <= HI1) begin
      r = {1'b1, 2'd1};
    end else if (mx >= LO2 && mx <= HI2) begin
      r = {1'b1, 2'd2};
    end else if (mx >= LO3 && mx <= HI3) begin
      r = {1'b1, 2'd3};
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [1:0]    cand_q, cand_d;
  logic          cand_vld_q, cand_vld_d;
  logic [1:0]    rate_sel_q, rate_sel_d;
  logic          rate_valid_q, rate_valid_d;
  logic [CW-1:0] half_period_q, half_period_d;
  logic          meas_done_q, meas_done_d;
  logic          no_signal_q, no_signal_d;

  logic          edge_s;
  logic          timeout_s;
  logic [2:0]    cls_s;
  logic          cls_hit_s;
  logic [1:0]    cls_sel_s;

  assign edge_s    = s2_q ^ s3_q;
  assign timeout_s = (cnt_q == MAXCNT) && !edge_s;
  assign cls_s     = classify(cnt_q);
  assign cls_hit_s = cls_s[2];
  assign cls_sel_s = cls_s[1:0];

  // Interval counter: restart at 1 on every edge, otherwise count up and hold at MAXCNT.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_s) begin
      cnt_d = CW'(1);
    end else if (cnt_q != MAXCNT) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Lock state machine: next state, candidate class and status outputs.
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cand_vld_d    = cand_vld_q;
    rate_sel_d    = rate_sel_q;
    rate_valid_d  = rate_valid_q;
    half_period_d = half_period_q;
    meas_done_d   = 1'b0;
    no_signal_d   = no_signal_q;
    case (state_q)
      IDLE: begin
        // The first interval after idle is partial, so it is not measured.
        if (edge_s) begin
          state_d     = MEASURE;
          cand_vld_d  = 1'b0;
          no_signal_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (edge_s) begin
          half_period_d = cnt_q;
          meas_done_d   = 1'b1;
          if (cls_hit_s && cand_vld_q && (cls_sel_s == cand_q)) begin
            state_d      = LOCKED;
            rate_sel_d   = cls_sel_s;
            rate_valid_d = 1'b1;
          end else if (cls_hit_s) begin
            cand_d     = cls_sel_s;
            cand_vld_d = 1'b1;
          end else begin
            cand_vld_d = 1'b0;
          end
        end else if (timeout_s) begin
          state_d      = IDLE;
          rate_valid_d = 1'b0;
          no_signal_d  = 1'b1;
          cand_vld_d   = 1'b0;
        end else begin
          state_d = MEASURE;
        end
      end
      LOCKED: begin
        if (edge_s) begin
          half_period_d = cnt_q;
          meas_done_d   = 1'b1;
          if (cls_hit_s && (cls_sel_s == rate_sel_q)) begin
            state_d = LOCKED;
          end else begin
            state_d      = MEASURE;
            rate_valid_d = 1'b0;
            cand_d       = cls_sel_s;
            cand_vld_d   = cls_hit_s;
          end
        end else if (timeout_s) begin
          state_d      = IDLE;
          rate_valid_d = 1'b0;
          no_signal_d  = 1'b1;
          cand_vld_d   = 1'b0;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d      = IDLE;
        rate_valid_d = 1'b0;
        cand_vld_d   = 1'b0;
      end
    endcase
  end

  // All state registers, cleared asynchronously by rstN.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      cnt_q         <= '0;
      state_q       <= IDLE;
      cand_q        <= 2'd0;
      cand_vld_q    <= 1'b0;
      rate_sel_q    <= 2'd0;
      rate_valid_q  <= 1'b0;
      half_period_q <= '0;
      meas_done_q   <= 1'b0;
      no_signal_q   <= 1'b0;
    end else begin
      s1_q          <= divClkIn;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cand_vld_q    <= cand_vld_d;
      rate_sel_q    <= rate_sel_d;
      rate_valid_q  <= rate_valid_d;
      half_period_q <= half_period_d;
      meas_done_q   <= meas_done_d;
      no_signal_q   <= no_signal_d;
    end
  end

  assign rateSel    = rate_sel_q;
  assign rateValid  = rate_valid_q;
  assign halfPeriod = half_period_q;
  assign measDone   = meas_done_q;
  assign noSignal   = no_signal_q;

endmodule

// File: tb/tb_rate_detect.sv
// tb_rate_detect: scoreboard bench for rate_detect. Stimulus is a sequence of
// toggle gaps; a behavioural model predicts each measurement/timeout event and
// a separate monitor compares them against the DUT outputs.
module tb_rate_detect;
  localparam int CW     = 8;
  localparam int TOL    = 1;
  localparam int MAXCNT = 35;

  logic          clk = 1'b0;
  logic          rstN;
  logic          divClkIn;
  logic [1:0]    rateSel;
  logic          rateValid;
  logic [CW-1:0] halfPeriod;
  logic          measDone;
  logic          noSignal;

  rate_detect #(
    .CW(CW), .HALF0(5), .HALF1(9), .HALF2(17), .HALF3(33), .TOL(TOL)
  ) dut (
    .clk(clk), .rstN(rstN), .divClkIn(divClkIn), .rateSel(rateSel),
    .rateValid(rateValid), .halfPeriod(halfPeriod), .measDone(measDone),
    .noSignal(noSignal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_to;
    int hp;
    bit vld;
    int sel;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: 0 idle, 1 searching, 2 locked.
  int m_state  = 0;
  int m_cand   = 0;
  bit m_cand_v = 0;
  bit m_vld    = 0;
  int m_sel    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int half_of(input int k);
    case (k)
      0:       return 5;
      1:       return 9;
      2:       return 17;
      default: return 33;
    endcase
  endfunction

  // Rate class of a measured half-period, -1 when it is within no window.
  function automatic int cls_of(input int m);
    for (int k = 0; k < 4; k++) begin
      int d;
      d = m - half_of(k);
      if (d < 0) d = -d;
      if (d <= TOL) return k;
    end
    return -1;
  endfunction

  // Predict what the next toggle, n cycles after the previous one, produces.
  task automatic predict(input int n);
    exp_t e;
    int   c;
    if (m_state != 0 && n > MAXCNT) begin
      e.is_to = 1; e.hp = 0; e.vld = 0; e.sel = 0;
      q.push_back(e);
      m_state = 0; m_vld = 0; m_cand_v = 0;
    end
    if (m_state == 0) begin
      m_state  = 1;
      m_cand_v = 0;
    end else begin
      c = cls_of(n);
      if (m_state == 1) begin
        if (c >= 0 && m_cand_v && c == m_cand) begin
          m_state = 2; m_vld = 1; m_sel = c;
        end else if (c >= 0) begin
          m_cand = c; m_cand_v = 1;
        end else begin
          m_cand_v = 0;
        end
      end else begin
        if (c != m_sel) begin
          m_state = 1; m_vld = 0;
          m_cand = c; m_cand_v = (c >= 0);
        end
      end
      e.is_to = 0; e.hp = n; e.vld = m_vld; e.sel = m_sel;
      q.push_back(e);
    end
  endtask

  task automatic gap(input int n);
    predict(n);
    repeat (n) @(posedge clk);
    #1 divClkIn = ~divClkIn;
  endtask

  task automatic model_reset();
    m_state = 0; m_cand = 0; m_cand_v = 0; m_vld = 0; m_sel = 0;
    q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rateSel"}, rateSel, 0);
    chk({tag, "_rateValid"}, rateValid, 0);
    chk({tag, "_halfPeriod"}, halfPeriod, 0);
    chk({tag, "_measDone"}, measDone, 0);
    chk({tag, "_noSignal"}, noSignal, 0);
  endtask

  // Monitor: pops one expected event whenever the DUT reports a measurement or a timeout.
  initial begin
    bit   prev_ns;
    exp_t e;
    prev_ns = 0;
    forever begin
      @(negedge clk);
      if (rstN === 1'b1) begin
        if (measDone === 1'b1) begin
          if (q.size() == 0) begin
            chk("unexpected_meas", 1, 0);
          end else begin
            e = q.pop_front();
            chk("meas_event_kind", e.is_to, 0);
            chk("half_period", halfPeriod, e.hp);
            chk("rate_valid", rateValid, e.vld);
            if (e.vld) chk("rate_sel", rateSel, e.sel);
            chk("no_signal_clear", noSignal, 0);
          end
        end
        if (noSignal === 1'b1 && !prev_ns) begin
          if (q.size() == 0) begin
            chk("unexpected_timeout", 1, 0);
          end else begin
            e = q.pop_front();
            chk("timeout_event_kind", e.is_to, 1);
            chk("timeout_rate_valid", rateValid, 0);
          end
        end
        prev_ns = noSignal;
      end else begin
        prev_ns = 0;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstN     = 1'b0;
    divClkIn = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    // Lock at select 01 from reset.
    gap(3); gap(9); gap(9);
    // Within-tolerance intervals keep lock, then an out-of-window one drops it.
    gap(10); gap(8); gap(11);
    // Relock at 01, then move to 17-cycle toggling.
    gap(9); gap(9); gap(17); gap(17);
    // Stop toggling long enough to time out, then resume at 5 cycles.
    gap(40); gap(5); gap(5);
    // Boundary: interval of exactly MAXCNT is a measurement of class NONE.
    gap(35); gap(5); gap(5);
    // Glitch between 9-cycle intervals.
    gap(9); gap(9); gap(3); gap(9); gap(9);

    // Asynchronous reset in the middle of a clock period while locked.
    repeat (5) @(posedge clk);
    chk("pre_reset_locked", rateValid, 1);
    chk("pre_reset_queue_empty", q.size(), 0);
    #3 rstN = 1'b0;
    divClkIn = 1'b0;
    #1 check_outputs_zero("async_reset");
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    gap(3); gap(33); gap(33);

    // Randomized gaps: mostly near the nominal half-periods, some arbitrary.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        n = half_of(int'($urandom_range(0, 3))) + int'($urandom_range(0, 2)) - 1;
      end else begin
        n = int'($urandom_range(2, 40));
      end
      gap(n);
    end

    repeat (10) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
